// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencer: integrator/comb strobes, runtime rate changes with clear + flush masking.
// Optional CIC_DECIM_CTRL_CFG_ERR_EN: reject illegal rates and pulse cfg_err instead of clamping.
module cic_decim_ctrl #(
  parameter int MAX_R     = 64,
  parameter int R_WIDTH   = 7,
  parameter int CIC_N     = 3,
  parameter int DEFAULT_R = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_in_tvalid,
  input  logic [R_WIDTH-1:0] s_axis_cfg_tdata,
  input  logic               s_axis_cfg_tvalid,
  output logic               s_axis_cfg_tready,
  output logic               integ_en,
  output logic               comb_en,
  output logic               dp_clear,
  output logic               out_en,
  output logic [R_WIDTH-1:0] cur_r,
  output logic               busy
`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
  ,
  output logic               cfg_err
`endif
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int FW = (CIC_N > 0) ? $clog2(CIC_N + 1) : 1;
  localparam logic [FW-1:0]      FLUSH_INIT = FW'(CIC_N);
  localparam logic [R_WIDTH-1:0] MAX_RV     = R_WIDTH'(MAX_R);
  localparam logic [R_WIDTH-1:0] DEF_RV     = R_WIDTH'(DEFAULT_R);

  logic [1:0]         state;
  logic [R_WIDTH-1:0] counter;
  logic [FW-1:0]      flush_cnt;
  logic [R_WIDTH-1:0] r_last;
  logic [R_WIDTH-1:0] rate_new;
  logic               accept;
  logic               rate_bad;
  logic               rate_take;

  assign s_axis_cfg_tready = (state == RUN);
  assign busy              = (state != RUN);
  assign out_en            = (state == RUN);
  assign dp_clear          = (state == CLEAR);
  assign integ_en          = s_axis_in_tvalid && (state != CLEAR);

  // cur_r is never 0, so cur_r-1 cannot underflow
  assign r_last  = cur_r - R_WIDTH'(1);
  assign comb_en = integ_en && (counter == r_last);

  assign accept   = s_axis_cfg_tvalid && s_axis_cfg_tready;
  assign rate_bad = (s_axis_cfg_tdata == '0) || (s_axis_cfg_tdata > MAX_RV);

`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
  assign rate_take = accept && !rate_bad;
  assign rate_new  = s_axis_cfg_tdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= accept && rate_bad;
  end
`else
  assign rate_take = accept;

  always_comb begin
    rate_new = s_axis_cfg_tdata;
    if (s_axis_cfg_tdata == '0)        rate_new = R_WIDTH'(1);
    else if (s_axis_cfg_tdata > MAX_RV) rate_new = MAX_RV;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cur_r     <= DEF_RV;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (rate_take) begin
            cur_r <= rate_new;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          state     <= FLUSH;
          flush_cnt <= FLUSH_INIT;
        end
        FLUSH: begin
          // flush_cnt==0 on entry only when there are no comb stages to settle
          if (flush_cnt == '0) begin
            state <= RUN;
          end else if (comb_en) begin
            flush_cnt <= flush_cnt - FW'(1);
            if (flush_cnt == FW'(1)) state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // an input coinciding with acceptance still counts at the old rate; CLEAR then zeroes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                counter <= '0;
    else if (state == CLEAR)  counter <= '0;
    else if (integ_en)        counter <= (counter == r_last) ? '0 : counter + R_WIDTH'(1);
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Randomised bench for cic_decim_ctrl against a counting model of decimation and flush behaviour.
module tb_cic_decim_ctrl;
  localparam int MAX_R     = 64;
  localparam int R_WIDTH   = 7;
  localparam int CIC_N     = 3;
  localparam int DEFAULT_R = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_axis_in_tvalid;
  logic [R_WIDTH-1:0] s_axis_cfg_tdata;
  logic               s_axis_cfg_tvalid;
  logic               s_axis_cfg_tready;
  logic               integ_en;
  logic               comb_en;
  logic               dp_clear;
  logic               out_en;
  logic [R_WIDTH-1:0] cur_r;
  logic               busy;
`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
  logic               cfg_err;
`endif

  always #5 clk = ~clk;

  cic_decim_ctrl #(.MAX_R(MAX_R), .R_WIDTH(R_WIDTH), .CIC_N(CIC_N), .DEFAULT_R(DEFAULT_R)) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .s_axis_cfg_tdata  (s_axis_cfg_tdata),
    .s_axis_cfg_tvalid (s_axis_cfg_tvalid),
    .s_axis_cfg_tready (s_axis_cfg_tready),
    .integ_en          (integ_en),
    .comb_en           (comb_en),
    .dp_clear          (dp_clear),
    .out_en            (out_en),
    .cur_r             (cur_r),
    .busy              (busy)
`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
    ,
    .cfg_err           (cfg_err)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model: 0 = running, 1 = clearing, 2 = flushing
  int m_mode, m_rate, m_cnt, m_combs;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_rate  = DEFAULT_R;
    m_cnt   = 0;
    m_combs = 0;
    m_err   = 1'b0;
  endtask

  task automatic cycle(input bit vld, input bit cv, input int cd, output bit acc);
    bit e_integ, e_comb;
    @(negedge clk);
    s_axis_in_tvalid  = vld;
    s_axis_cfg_tvalid = cv;
    s_axis_cfg_tdata  = cd[R_WIDTH-1:0];
    #1;
    e_integ = vld && (m_mode != 1);
    e_comb  = e_integ && (((m_cnt + 1) % m_rate) == 0);
    check("tready",   32'(s_axis_cfg_tready), 32'(m_mode == 0));
    check("busy",     32'(busy),              32'(m_mode != 0));
    check("out_en",   32'(out_en),            32'(m_mode == 0));
    check("dp_clear", 32'(dp_clear),          32'(m_mode == 1));
    check("integ_en", 32'(integ_en),          32'(e_integ));
    check("comb_en",  32'(comb_en),           32'(e_comb));
    check("cur_r",    32'(cur_r),             32'(m_rate));
`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
    check("cfg_err",  32'(cfg_err),           32'(m_err));
`endif
    @(posedge clk);
    acc   = cv && (m_mode == 0);
    m_err = 1'b0;
    case (m_mode)
      0: begin
        if (e_integ) m_cnt++;
        if (acc) begin
`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
          if (cd == 0 || cd > MAX_R) m_err = 1'b1;
          else begin
            m_rate = cd;
            m_mode = 1;
          end
`else
          m_rate = (cd == 0) ? 1 : ((cd > MAX_R) ? MAX_R : cd);
          m_mode = 1;
`endif
        end
      end
      1: begin
        m_cnt   = 0;
        m_combs = 0;
        m_mode  = 2;
      end
      default: begin
        if (e_integ) m_cnt++;
        if (e_comb) m_combs++;
        if (m_combs >= CIC_N) m_mode = 0;
      end
    endcase
  endtask

  task automatic idle(input int n, input int pct);
    bit acc;
    for (int i = 0; i < n; i++) cycle($urandom_range(0, 99) < pct, 1'b0, 0, acc);
  endtask

  // holds the request until the handshake completes, as a compliant requester would
  task automatic request(input int rate, input int pct);
    bit acc;
    int k;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 300) begin
      cycle($urandom_range(0, 99) < pct, 1'b1, rate, acc);
      k++;
    end
    check("req_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_run(input int pct);
    int k;
    k = 0;
    while (m_mode != 0 && k < 1000) begin
      idle(1, pct);
      k++;
    end
    check("flush_done", 32'(m_mode), 32'd0);
  endtask

  initial begin
    reset             = 1'b1;
    s_axis_in_tvalid  = 1'b0;
    s_axis_cfg_tvalid = 1'b0;
    s_axis_cfg_tdata  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_tready",   32'(s_axis_cfg_tready), 32'd1);
    check("rst_out_en",   32'(out_en),            32'd1);
    check("rst_busy",     32'(busy),              32'd0);
    check("rst_dp_clear", 32'(dp_clear),          32'd0);
    check("rst_comb_en",  32'(comb_en),           32'd0);
    check("rst_integ_en", 32'(integ_en),          32'd0);
    check("rst_cur_r",    32'(cur_r),             32'(DEFAULT_R));
`ifdef CIC_DECIM_CTRL_CFG_ERR_EN
    check("rst_cfg_err",  32'(cfg_err),           32'd0);
`endif
    reset = 1'b0;

    idle(16, 100);
    request(8, 100);
    request(2, 100);
    wait_run(100);
    idle(10, 60);

    request(1, 70);
    wait_run(70);
    idle(10, 70);
    request(0, 70);
    wait_run(70);
    idle(6, 70);
    request(100, 70);
    wait_run(70);
    idle(8, 70);

    for (int i = 0; i < 8; i++) begin
      request($urandom_range(0, 80), $urandom_range(30, 100));
      if ($urandom_range(0, 1) == 1) wait_run(80);
      idle($urandom_range(0, 20), $urandom_range(20, 100));
    end
    wait_run(100);

    request(16, 100);
    idle(4, 100);
    @(negedge clk);
    s_axis_in_tvalid  = 1'b0;
    s_axis_cfg_tvalid = 1'b0;
    reset             = 1'b1;
    #1;
    check("midrst_cur_r",  32'(cur_r),             32'(DEFAULT_R));
    check("midrst_out_en", 32'(out_en),            32'd1);
    check("midrst_tready", 32'(s_axis_cfg_tready), 32'd1);
    check("midrst_busy",   32'(busy),              32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(12, 100);
    idle(20, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencer for the CIC decimation datapath: it converts the upstream sample-valid stream into integrator-enable and comb/decimation strobes, holds the current decimation rate R, and accepts runtime rate changes over an AXI-Stream-style config port. On a rate change it clears the datapath, then masks output valids until the comb section has settled at the new rate. It sits beside the integrator chain, downsampler and comb chain and drives their enables; it carries no sample data.

## Interface
- `MAX_R`, 64: largest legal decimation rate.
- `R_WIDTH`, 7: width of rate values; must satisfy 2^R_WIDTH > MAX_R.
- `CIC_N`, 3: number of comb stages, which is also the number of settling outputs to mask after a rate change.
- `DEFAULT_R`, 4: rate loaded at reset; must satisfy 1 ≤ DEFAULT_R ≤ MAX_R.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `s_axis_in_tvalid`, in, 1: upstream sample strobe.
- `s_axis_cfg_tdata`, in, R_WIDTH: requested rate.
- `s_axis_cfg_tvalid`, in, 1: config request valid.
- `s_axis_cfg_tready`, out, 1: config can be accepted.
- `integ_en`, out, 1: integrator chain advance enable.
- `comb_en`, out, 1: decimation strobe that advances the downsampler and comb chain.
- `dp_clear`, out, 1: synchronous clear of all integrator, comb and downsampler state.
- `out_en`, out, 1: AND-mask for the final `m_axis_out_tvalid`.
- `cur_r`, out, R_WIDTH: active rate.
- `busy`, out, 1: rate change in progress.
- `cfg_err`, out, 1: present only with CIC_DECIM_CTRL_CFG_ERR_EN; pulses when an illegal rate is received.

## Operation
- States:
  - RUN: normal decimation.
  - CLEAR: exactly 1 cycle.
  - FLUSH: masks outputs while the combs settle.
- Registered state: `state`, `cur_r`, `counter` (R_WIDTH bits) and `flush_cnt` ($clog2(CIC_N+1) bits).
- Combinational outputs:
  - `s_axis_cfg_tready = (state==RUN)`.
  - `busy = (state!=RUN)`.
  - `out_en = (state==RUN)`.
  - `dp_clear = (state==CLEAR)`.
  - `integ_en = s_axis_in_tvalid && state!=CLEAR`.
  - `comb_en = integ_en && counter==cur_r-1`.
- Counter:
  - On `integ_en`, `counter` advances by 1; when `counter==cur_r-1` it wraps to 0 instead.
  - In CLEAR, `counter` is forced to 0.
  - With R=1, `counter` stays at 0 and `comb_en` equals `integ_en`.
- Config accept: a handshake completes when `tvalid && tready`. On acceptance, `cur_r` is loaded with the new rate and the next state is CLEAR.
- CLEAR → FLUSH unconditionally; `flush_cnt` is loaded with CIC_N.
- In FLUSH, each `comb_en` decrements `flush_cnt`. The `comb_en` that takes `flush_cnt` from 1 to 0 transitions the state to RUN. With CIC_N=0, FLUSH exits on the next cycle.
- Config requests during CLEAR or FLUSH are stalled (`tready`=0). The requester must hold `tdata` until accepted.
- A request equal to `cur_r` still performs a full CLEAR/FLUSH sequence.

## Timing
- Reset values:
  - state RUN, `cur_r`=DEFAULT_R, `counter`=0, `flush_cnt`=0.
  - Outputs: `s_axis_cfg_tready`=1, `out_en`=1, `busy`=0, `dp_clear`=0, `comb_en`=0, `integ_en`=0, `cfg_err`=0.
- `comb_en` and `integ_en` are combinational from `s_axis_in_tvalid`, with 0-cycle latency. The first `comb_en` after reset is on the DEFAULT_R-th valid input.
- Accept at edge k:
  - `cur_r` is new and `dp_clear`=1 for the cycle k..k+1; `integ_en`=0 in that cycle, even if an input is valid.
  - FLUSH starts after edge k+1.
  - An input arriving in the CLEAR cycle is dropped and not counted.
- `out_en` deasserts during the cycle after acceptance and reasserts the cycle after the CIC_N-th post-clear `comb_en`.
- Reset asserted mid-FLUSH returns immediately to reset values, including `cur_r`=DEFAULT_R.
- A valid input coinciding with config acceptance is counted at the old rate; the counter is then zeroed in CLEAR.

## Configuration
- The feature is controlled by the macro `CIC_DECIM_CTRL_CFG_ERR_EN`. A rate is illegal when it is 0 or greater than MAX_R.
- Defined:
  - The `cfg_err` port exists.
  - An illegal rate is accepted by handshake, but ignored: no CLEAR, `cur_r` is unchanged and the state stays RUN.
  - `cfg_err` is registered and pulses high for 1 cycle after the accepting edge.
- Undefined:
  - The `cfg_err` port is absent.
  - An illegal rate is clamped: 0 → 1, and values above MAX_R → MAX_R.
  - The normal rate-change sequence then follows.

## Test plan
- Reset, then 16 consecutive valid inputs with DEFAULT_R=4 → `comb_en` on inputs 4, 8, 12 and 16; `out_en`=1 throughout; `cur_r`=4.
- Write R=8 during RUN with continuous valid input → `dp_clear` for exactly 1 cycle; `out_en`=0 until the 3rd subsequent `comb_en` (24 accepted inputs), then 1; `busy` mirrors `~out_en`.
- Assert `cfg_tvalid` with R=2 during FLUSH → `tready`=0 until RUN, then accepted; a second CLEAR/FLUSH follows.
- Write R=1 → after flush, `comb_en`=`integ_en` on every valid input; write R=0 → with the macro defined, `cfg_err` pulses and `cur_r` stays 1; with the macro undefined, `cur_r`=1 and CLEAR occurs.
- Write R=100 with MAX_R=64 → with the macro defined, `cfg_err` pulses and `cur_r` is unchanged; with the macro undefined, `cur_r`=64.
- Assert `reset` mid-FLUSH after writing R=16 → next cycle `cur_r`=4, `out_en`=1, `tready`=1, `counter`=0.
